// File: rtl/myo_status_frame_collector.sv
// Collects 8-word SPI status frames from a myo motor driver board, checks framing and
// XOR checksum, and commits good frames into per-motor position/velocity/current/displacement registers.
module myo_status_frame_collector #(
    parameter int NUMBER_OF_MOTORS = 6,
    parameter int MOTOR_IDX_W      = 4,
    parameter int STALE_CYCLES     = 500000
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          frame_start,
    input  logic [MOTOR_IDX_W-1:0]        motor_select,
    input  logic                          word_valid,
    input  logic [15:0]                   word_data,
    input  logic                          frame_end,
    output logic [32*NUMBER_OF_MOTORS-1:0] positions,
    output logic [16*NUMBER_OF_MOTORS-1:0] velocities,
    output logic [16*NUMBER_OF_MOTORS-1:0] currents,
    output logic [32*NUMBER_OF_MOTORS-1:0] displacements,
    output logic                          update_valid,
    output logic [MOTOR_IDX_W-1:0]        update_motor,
    output logic [15:0]                   checksum_errors,
    output logic [15:0]                   framing_errors,
    output logic [NUMBER_OF_MOTORS-1:0]   motor_stale
);

    localparam int STALE_W = $clog2(STALE_CYCLES + 1);
    localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_CYCLES);
    localparam logic [15:0] HEADER_WORD = 16'h8000;

    typedef enum logic [1:0] {IDLE, CAPTURE, DISCARD} state_t;

    state_t                 state, next_state;
    logic [MOTOR_IDX_W-1:0] motor_q;
    logic [3:0]             word_count;
    logic [15:0]            words     [8];
    logic [15:0]            eff_words [8];
    logic [3:0]             eff_count;
    logic [15:0]            xor_sum;
    logic                   store_word;
    logic                   hdr_len_ok;
    logic                   select_ok;
    logic                   commit;
    logic                   framing_inc;
    logic                   checksum_inc;
    logic [STALE_W-1:0]     stale_cnt [NUMBER_OF_MOTORS];

    // The frame is judged including a word that arrives in the frame_end cycle,
    // so evaluation works on the "after this cycle" view of the word buffer.
    always_comb begin
        eff_words  = words;
        eff_count  = word_count;
        store_word = (state == CAPTURE) && word_valid && !frame_start;
        if (store_word) begin
            if (word_count < 4'd8) begin
                eff_words[word_count[2:0]] = word_data;
            end
            if (word_count != 4'd9) begin
                eff_count = word_count + 4'd1;
            end
        end
        xor_sum    = eff_words[1] ^ eff_words[2] ^ eff_words[3] ^
                     eff_words[4] ^ eff_words[5] ^ eff_words[6];
        hdr_len_ok = (eff_count == 4'd8) && (eff_words[0] == HEADER_WORD);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A new frame_start always wins; restarting mid-frame counts as a framing error.
    always_comb begin
        next_state   = state;
        commit       = 1'b0;
        framing_inc  = 1'b0;
        checksum_inc = 1'b0;
        select_ok    = 32'(motor_select) < NUMBER_OF_MOTORS;
        if (frame_start) begin
            if (state != IDLE) begin
                framing_inc = 1'b1;
            end
            next_state = select_ok ? CAPTURE : DISCARD;
        end else begin
            case (state)
                CAPTURE: begin
                    if (frame_end) begin
                        next_state = IDLE;
                        if (!hdr_len_ok) begin
                            framing_inc = 1'b1;
                        end else if (xor_sum != eff_words[7]) begin
                            checksum_inc = 1'b1;
                        end else begin
                            commit = 1'b1;
                        end
                    end
                end
                DISCARD: begin
                    if (frame_end) begin
                        next_state  = IDLE;
                        framing_inc = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            motor_q    <= '0;
            word_count <= '0;
            for (int i = 0; i < 8; i++) begin
                words[i] <= '0;
            end
        end else if (frame_start) begin
            motor_q <= motor_select;
            if (word_valid) begin
                words[0]   <= word_data;
                word_count <= 4'd1;
            end else begin
                word_count <= 4'd0;
            end
        end else if (store_word) begin
            words      <= eff_words;
            word_count <= eff_count;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            checksum_errors <= '0;
            framing_errors  <= '0;
            update_valid    <= 1'b0;
            update_motor    <= '0;
        end else begin
            if (framing_inc && framing_errors != 16'hFFFF) begin
                framing_errors <= framing_errors + 16'd1;
            end
            if (checksum_inc && checksum_errors != 16'hFFFF) begin
                checksum_errors <= checksum_errors + 16'd1;
            end
            update_valid <= commit;
            if (commit) begin
                update_motor <= motor_q;
            end
        end
    end

    // Per-motor data and staleness; only the committed motor is written.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            positions     <= '0;
            velocities    <= '0;
            currents      <= '0;
            displacements <= '0;
            for (int m = 0; m < NUMBER_OF_MOTORS; m++) begin
                stale_cnt[m] <= STALE_MAX;
            end
        end else begin
            for (int m = 0; m < NUMBER_OF_MOTORS; m++) begin
                if (commit && (motor_q == MOTOR_IDX_W'(m))) begin
                    positions[32*m +: 32]     <= {eff_words[1], eff_words[2]};
                    velocities[16*m +: 16]    <= eff_words[3];
                    currents[16*m +: 16]      <= eff_words[4];
                    displacements[32*m +: 32] <= {eff_words[5], eff_words[6]};
                    stale_cnt[m]              <= '0;
                end else if (stale_cnt[m] != STALE_MAX) begin
                    stale_cnt[m] <= stale_cnt[m] + STALE_W'(1);
                end
            end
        end
    end

    always_comb begin
        motor_stale = '0;
        for (int m = 0; m < NUMBER_OF_MOTORS; m++) begin
            motor_stale[m] = (stale_cnt[m] == STALE_MAX);
        end
    end

endmodule

// File: tb/tb_myo_status_frame_collector.sv
// Self-checking bench for myo_status_frame_collector: directed frames from the test plan
// followed by randomized frames, all checked against a frame-level reference model.
module tb_myo_status_frame_collector;

    localparam int NM = 6;
    localparam int IW = 4;
    localparam int SC = 100;

    logic            clock;
    logic            reset_n;
    logic            frame_start;
    logic [IW-1:0]   motor_select;
    logic            word_valid;
    logic [15:0]     word_data;
    logic            frame_end;
    logic [32*NM-1:0] positions;
    logic [16*NM-1:0] velocities;
    logic [16*NM-1:0] currents;
    logic [32*NM-1:0] displacements;
    logic            update_valid;
    logic [IW-1:0]   update_motor;
    logic [15:0]     checksum_errors;
    logic [15:0]     framing_errors;
    logic [NM-1:0]   motor_stale;

    myo_status_frame_collector #(
        .NUMBER_OF_MOTORS(NM),
        .MOTOR_IDX_W(IW),
        .STALE_CYCLES(SC)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .frame_start(frame_start),
        .motor_select(motor_select),
        .word_valid(word_valid),
        .word_data(word_data),
        .frame_end(frame_end),
        .positions(positions),
        .velocities(velocities),
        .currents(currents),
        .displacements(displacements),
        .update_valid(update_valid),
        .update_motor(update_motor),
        .checksum_errors(checksum_errors),
        .framing_errors(framing_errors),
        .motor_stale(motor_stale)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [31:0] exp_pos  [NM];
    logic [15:0] exp_vel  [NM];
    logic [15:0] exp_cur  [NM];
    logic [31:0] exp_disp [NM];
    bit          committed [NM];
    int          last_commit [NM];
    int          exp_framing;
    int          exp_checksum;
    logic [IW-1:0] exp_umotor;
    bit          in_frame;

    logic [15:0] fw [16];
    int          fn;

    function automatic logic [15:0] sat16(input int v);
        logic [31:0] t;
        t = v;
        return (v > 65535) ? 16'hFFFF : t[15:0];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic modelReset();
        for (int m = 0; m < NM; m++) begin
            exp_pos[m] = '0; exp_vel[m] = '0; exp_cur[m] = '0; exp_disp[m] = '0;
            committed[m] = 0; last_commit[m] = 0;
        end
        exp_framing = 0; exp_checksum = 0; exp_umotor = '0; in_frame = 0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string where);
        logic [NM-1:0] exp_stale;
        for (int m = 0; m < NM; m++) begin
            exp_stale[m] = !committed[m] || ((cyc - last_commit[m]) >= SC);
            checkOutput($sformatf("%s pos%0d", where, m), positions[32*m +: 32], exp_pos[m]);
            checkOutput($sformatf("%s vel%0d", where, m), {16'h0, velocities[16*m +: 16]}, {16'h0, exp_vel[m]});
            checkOutput($sformatf("%s cur%0d", where, m), {16'h0, currents[16*m +: 16]}, {16'h0, exp_cur[m]});
            checkOutput($sformatf("%s disp%0d", where, m), displacements[32*m +: 32], exp_disp[m]);
        end
        checkOutput({where, " framing_errors"}, 32'(framing_errors), 32'(sat16(exp_framing)));
        checkOutput({where, " checksum_errors"}, 32'(checksum_errors), 32'(sat16(exp_checksum)));
        checkOutput({where, " motor_stale"}, 32'(motor_stale), 32'(exp_stale));
        checkOutput({where, " update_motor"}, 32'(update_motor), 32'(exp_umotor));
    endtask

    function automatic logic [15:0] xorOf();
        return fw[1] ^ fw[2] ^ fw[3] ^ fw[4] ^ fw[5] ^ fw[6];
    endfunction

    task automatic makeGood(input logic [15:0] a, b, c, d, e, f);
        fn = 8; fw[0] = 16'h8000;
        fw[1] = a; fw[2] = b; fw[3] = c; fw[4] = d; fw[5] = e; fw[6] = f;
        fw[7] = xorOf();
    endtask

    // Drive one frame from fw[0..fn-1]; finish=0 leaves it open so the next start aborts it.
    task automatic applyStimulus(input int m, input bit w0_at_start, input bit last_at_end,
                                 input bit finish, input int gap_pct);
        int  i;
        bit  exp_commit;
        i = 0;
        exp_commit = 0;
        if (in_frame) exp_framing++;
        frame_start  = 1'b1;
        motor_select = IW'(m);
        if (w0_at_start && fn > 0) begin
            word_valid = 1'b1; word_data = fw[0]; i = 1;
        end
        tick();
        frame_start = 1'b0; word_valid = 1'b0;
        in_frame = 1;
        while (i < fn - ((last_at_end && finish) ? 1 : 0)) begin
            if (32'($urandom_range(0, 99)) < 32'(gap_pct)) begin
                word_valid = 1'b0; tick();
            end
            word_valid = 1'b1; word_data = fw[i]; i++;
            tick();
        end
        word_valid = 1'b0;
        if (!finish) return;
        if (last_at_end && i < fn) begin
            word_valid = 1'b1; word_data = fw[i]; i++;
        end
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0; word_valid = 1'b0;
        in_frame = 0;
        if (m >= NM) exp_framing++;
        else if (fn != 8 || fw[0] != 16'h8000) exp_framing++;
        else if (xorOf() != fw[7]) exp_checksum++;
        else begin
            exp_commit = 1;
            exp_pos[m] = {fw[1], fw[2]}; exp_vel[m] = fw[3]; exp_cur[m] = fw[4];
            exp_disp[m] = {fw[5], fw[6]};
            committed[m] = 1; last_commit[m] = cyc; exp_umotor = IW'(m);
        end
        checkOutput("update_valid_pulse", 32'(update_valid), 32'(exp_commit));
        checkAll("after_frame");
        tick();
        checkOutput("update_valid_drop", 32'(update_valid), 32'h0);
    endtask

    initial begin
        int wait_cnt;
        reset_n = 1'b1; frame_start = 1'b0; motor_select = '0;
        word_valid = 1'b0; word_data = '0; frame_end = 1'b0;
        modelReset();
        #2 reset_n = 1'b0;
        tick(); tick();
        checkAll("reset_held");
        checkOutput("reset update_valid", 32'(update_valid), 32'h0);
        checkOutput("reset motor_stale ones", 32'(motor_stale), 32'h3F);
        reset_n = 1'b1;
        tick();
        checkAll("reset_released");

        $display("[TB] directed good frame motor 2");
        makeGood(16'hFFFF, 16'hFF38, 16'h0064, 16'hFFF6, 16'h0000, 16'h01F4);
        applyStimulus(2, 0, 0, 1, 0);
        checkOutput("m2 position -200", positions[64 +: 32], 32'hFFFFFF38);
        checkOutput("m2 velocity 100", {16'h0, velocities[32 +: 16]}, 32'h0064);
        checkOutput("m2 current -10", {16'h0, currents[32 +: 16]}, 32'hFFF6);
        checkOutput("m2 displacement 500", displacements[64 +: 32], 32'h000001F4);
        checkOutput("m2 update_motor", 32'(update_motor), 32'h2);

        $display("[TB] checksum error motor 0");
        makeGood(16'h1234, 16'h5678, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
        fw[7] = fw[7] ^ 16'h0001;
        applyStimulus(0, 1, 1, 1, 30);
        checkOutput("checksum_errors is 1", 32'(checksum_errors), 32'h1);

        $display("[TB] short, long and bad header frames");
        makeGood(16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6);
        fn = 7;
        applyStimulus(1, 0, 0, 1, 0);
        makeGood(16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6);
        fn = 9; fw[8] = 16'hAAAA;
        applyStimulus(1, 0, 1, 1, 0);
        makeGood(16'h1, 16'h2, 16'h3, 16'h4, 16'h5, 16'h6);
        fw[0] = 16'h0000;
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput("framing_errors is 3", 32'(framing_errors), 32'h3);

        $display("[TB] abort mid-capture then good frame motor 1");
        makeGood(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666);
        fn = 4;
        applyStimulus(1, 0, 0, 0, 0);
        makeGood(16'h0ABC, 16'hDEF0, 16'h7FFF, 16'h8001, 16'h1357, 16'h2468);
        applyStimulus(1, 0, 0, 1, 0);
        checkOutput("framing_errors is 4", 32'(framing_errors), 32'h4);

        $display("[TB] out-of-range motor is discarded");
        makeGood(16'h9, 16'h8, 16'h7, 16'h6, 16'h5, 16'h4);
        applyStimulus(NM, 0, 0, 1, 0);

        $display("[TB] stale timing motor 3");
        makeGood(16'h0, 16'h3, 16'h3, 16'h3, 16'h0, 16'h3);
        applyStimulus(3, 0, 0, 1, 0);
        wait_cnt = 0;
        while ((cyc - last_commit[3]) < (SC - 1) && wait_cnt < 300) begin
            tick(); wait_cnt++;
        end
        checkOutput("stale3 at 99", 32'(motor_stale[3]), 32'h0);
        tick();
        checkOutput("stale3 at 100", 32'(motor_stale[3]), 32'h1);
        checkAll("stale_window");

        $display("[TB] randomized frames");
        for (int k = 0; k < 60; k++) begin
            int m, r;
            m = $urandom_range(0, 7);
            makeGood(16'($urandom), 16'($urandom), 16'($urandom),
                     16'($urandom), 16'($urandom), 16'($urandom));
            r = $urandom_range(0, 9);
            if (r == 0) fn = $urandom_range(0, 7);
            else if (r == 1) begin
                fn = $urandom_range(9, 10); fw[8] = 16'($urandom); fw[9] = 16'($urandom);
            end else if (r == 2) fw[0] = fw[0] ^ (16'h1 << $urandom_range(0, 15));
            else if (r == 3) fw[7] = fw[7] ^ (16'h1 << $urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) begin
                applyStimulus(m, 1'($urandom), 0, 0, 20);
            end else begin
                applyStimulus(m, 1'($urandom), 1'($urandom), 1, 20);
                if ($urandom_range(0, 3) == 0) begin
                    word_valid = 1'b1; word_data = 16'($urandom); frame_end = 1'b1;
                    tick();
                    word_valid = 1'b0; frame_end = 1'b0;
                    tick();
                    checkAll("idle_ignored");
                end
            end
        end

        $display("[TB] reset mid-frame");
        makeGood(16'h5, 16'h6, 16'h7, 16'h8, 16'h9, 16'hA);
        fn = 5;
        applyStimulus(4, 0, 0, 0, 0);
        reset_n = 1'b0;
        #1;
        modelReset();
        checkAll("async_reset");
        checkOutput("async_reset update_valid", 32'(update_valid), 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        makeGood(16'h0, 16'h4, 16'h4, 16'h4, 16'h0, 16'h4);
        applyStimulus(4, 0, 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
